// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline definitions: status codes, instruction codes, register ids
// and the writeback status FSM encoding.
package y86_pkg;

   localparam logic [2:0] SBUB = 3'd0;
   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SHLT = 3'd2;
   localparam logic [2:0] SADR = 3'd3;
   localparam logic [2:0] SINS = 3'd4;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [3:0] RNONE = 4'hF;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HALT = 2'd1,
      ERR  = 2'd2
   } wbState_e;

   function automatic logic isFault(input logic [2:0] s);
      return (s == SADR) || (s == SINS);
   endfunction

   // Entries that complete architecturally: normal instructions and the halt itself.
   function automatic logic isRetiring(input logic [2:0] s);
      return (s == SAOK) || (s == SHLT);
   endfunction

endpackage

// File: rtl/wb_status_fsm.sv
// Sticky processor status for the writeback stage: RUN/HALT/ERR state, the
// architectural status code and the retired-instruction counter.
module wb_status_fsm
   import y86_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       W_stat,
   input  logic             W_stall,
   output logic [2:0]       stat,
   output logic             halted,
   output logic [CNT_W-1:0] retired
);

   wbState_e   state;
   wbState_e   stateNext;
   logic [2:0] haltCode;
   logic [2:0] haltCodeNext;
   logic       retireEn;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= RUN;
         haltCode <= SAOK;
         retired  <= '0;
      end else begin
         state    <= stateNext;
         haltCode <= haltCodeNext;
         if (retireEn) begin
            retired <= retired + CNT_W'(1);
         end
      end
   end

   // W is flushed to bubbles once terminal, so the halting code is kept here.
   always_comb begin
      stateNext    = state;
      haltCodeNext = haltCode;
      retireEn     = 1'b0;
      stat         = haltCode;
      halted       = 1'b1;
      unique case (state)
         RUN: begin
            halted   = 1'b0;
            stat     = (W_stat == SBUB) ? SAOK : W_stat;
            retireEn = !W_stall && isRetiring(W_stat);
            if (W_stat == SHLT) begin
               stateNext    = HALT;
               haltCodeNext = W_stat;
            end else if (isFault(W_stat)) begin
               stateNext    = ERR;
               haltCodeNext = W_stat;
            end
         end
         HALT, ERR: begin
            stateNext = state;
         end
         default: begin
            stateNext = ERR;
         end
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// Y86-64 W pipeline register with register-file write qualification; status
// tracking and retirement counting live in wb_status_fsm.
module writeback_stage
   import y86_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        M_stat,
   input  logic [3:0]        M_icode,
   input  logic [3:0]        M_dstE,
   input  logic [3:0]        M_dstM,
   input  logic [DATA_W-1:0] M_valE,
   input  logic [DATA_W-1:0] m_valM,
   input  logic              W_stall,
   input  logic              W_bubble,
   output logic [2:0]        W_stat,
   output logic [3:0]        W_icode,
   output logic [3:0]        W_dstE,
   output logic [3:0]        W_dstM,
   output logic [DATA_W-1:0] W_valE,
   output logic [DATA_W-1:0] W_valM,
   output logic [3:0]        wb_dstE,
   output logic [3:0]        wb_dstM,
   output logic [2:0]        stat,
   output logic              halted,
   output logic [CNT_W-1:0]  retired
);

   logic loadBubble;
   logic loadM;

   // A terminal state flushes W; otherwise stall outranks bubble.
   always_comb begin
      loadBubble = !reset_n || halted || (!W_stall && W_bubble);
      loadM      = !loadBubble && !W_stall;
   end

   // M -> W stage boundary
   always_ff @(posedge clk) begin
      if (loadBubble) begin
         W_stat  <= SBUB;
         W_icode <= INOP;
         W_dstE  <= RNONE;
         W_dstM  <= RNONE;
         W_valE  <= '0;
         W_valM  <= '0;
      end else if (loadM) begin
         W_stat  <= M_stat;
         W_icode <= M_icode;
         W_dstE  <= M_dstE;
         W_dstM  <= M_dstM;
         W_valE  <= M_valE;
         W_valM  <= m_valM;
      end
   end

   // Only healthy instructions write; on a same-register dual write the
   // memory result wins, as popq %rsp requires.
   always_comb begin
      wb_dstE = RNONE;
      wb_dstM = RNONE;
      if ((W_stat == SAOK) && !halted) begin
         wb_dstM = W_dstM;
         wb_dstE = ((W_dstE == W_dstM) && (W_dstM != RNONE)) ? RNONE : W_dstE;
      end
   end

   wb_status_fsm #(
      .CNT_W(CNT_W)
   ) uStatus (
      .clk    (clk),
      .reset_n(reset_n),
      .W_stat (W_stat),
      .W_stall(W_stall),
      .stat   (stat),
      .halted (halted),
      .retired(retired)
   );

endmodule

// File: tb/tb_writeback_stage.sv
// Directed and randomized bench for writeback_stage against a behavioural model.
module tb_writeback_stage;

   localparam int DW = 64;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [2:0]    M_stat;
   logic [3:0]    M_icode, M_dstE, M_dstM;
   logic [DW-1:0] M_valE, m_valM;
   logic          W_stall, W_bubble;
   logic [2:0]    W_stat;
   logic [3:0]    W_icode, W_dstE, W_dstM;
   logic [DW-1:0] W_valE, W_valM;
   logic [3:0]    wb_dstE, wb_dstM;
   logic [2:0]    stat;
   logic          halted;
   logic [CW-1:0] retired;

   writeback_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .reset_n(reset_n),
      .M_stat(M_stat), .M_icode(M_icode), .M_dstE(M_dstE), .M_dstM(M_dstM),
      .M_valE(M_valE), .m_valM(m_valM), .W_stall(W_stall), .W_bubble(W_bubble),
      .W_stat(W_stat), .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM),
      .W_valE(W_valE), .W_valM(W_valM), .wb_dstE(wb_dstE), .wb_dstM(wb_dstM),
      .stat(stat), .halted(halted), .retired(retired)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: contents of W plus the architectural status.
   logic [2:0]    mStat;
   logic [3:0]    mIcode, mDstE, mDstM;
   logic [DW-1:0] mValE, mValM;
   bit            mHalted;
   logic [2:0]    mCode;
   logic [CW-1:0] mRetired;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic modelBubble();
      mStat = 3'd0; mIcode = 4'h1; mDstE = 4'hF; mDstM = 4'hF; mValE = '0; mValM = '0;
   endtask

   // Applies the rules for one rising edge using the inputs the DUT sampled.
   task automatic modelEdge();
      bit wasHalted;
      if (!reset_n) begin
         modelBubble();
         mHalted = 0; mCode = 3'd1; mRetired = '0;
         return;
      end
      wasHalted = mHalted;
      if (!wasHalted && !W_stall && (mStat == 3'd1 || mStat == 3'd2)) mRetired = mRetired + 1'b1;
      if (!wasHalted && (mStat == 3'd2 || mStat == 3'd3 || mStat == 3'd4)) begin
         mHalted = 1; mCode = mStat;
      end
      if (wasHalted) modelBubble();
      else if (W_stall) ;
      else if (W_bubble) modelBubble();
      else begin
         mStat = M_stat; mIcode = M_icode; mDstE = M_dstE; mDstM = M_dstM;
         mValE = M_valE; mValM = m_valM;
      end
   endtask

   task automatic checkAll();
      logic [3:0] expE, expM;
      logic [2:0] expStat;
      expE = 4'hF; expM = 4'hF;
      if (mStat == 3'd1 && !mHalted) begin
         expM = mDstM;
         expE = (mDstE == mDstM && mDstM != 4'hF) ? 4'hF : mDstE;
      end
      expStat = mHalted ? mCode : ((mStat == 3'd0) ? 3'd1 : mStat);
      chk("W_stat", W_stat, mStat);
      chk("W_icode", W_icode, mIcode);
      chk("W_dstE", W_dstE, mDstE);
      chk("W_dstM", W_dstM, mDstM);
      chk("W_valE", W_valE, mValE);
      chk("W_valM", W_valM, mValM);
      chk("wb_dstE", wb_dstE, expE);
      chk("wb_dstM", wb_dstM, expM);
      chk("stat", stat, expStat);
      chk("halted", halted, mHalted);
      chk("retired", retired, mRetired);
   endtask

   task automatic tick();
      @(posedge clk);
      modelEdge();
      #1;
      checkAll();
   endtask

   task automatic setM(input logic [2:0] s, input logic [3:0] ic, input logic [3:0] dE,
                       input logic [3:0] dM, input logic [DW-1:0] vE, input logic [DW-1:0] vM);
      M_stat = s; M_icode = ic; M_dstE = dE; M_dstM = dM; M_valE = vE; m_valM = vM;
   endtask

   logic [CW-1:0] r;

   initial begin
      reset_n = 1'b0; W_stall = 1'b0; W_bubble = 1'b0;
      setM(3'd0, 4'h1, 4'hF, 4'hF, '0, '0);
      modelBubble(); mHalted = 0; mCode = 3'd1; mRetired = '0;

      // Reset
      tick();
      chk("rst_W_stat", W_stat, 3'd0);
      chk("rst_W_dstE", W_dstE, 4'hF);
      chk("rst_wb_dstM", wb_dstM, 4'hF);
      chk("rst_stat", stat, 3'd1);
      chk("rst_halted", halted, 1'b0);
      chk("rst_retired", retired, 0);
      reset_n = 1'b1;

      // Normal flow
      setM(3'd1, 4'h6, 4'd3, 4'hF, 64'h55, '0);
      tick();
      chk("norm_W_dstE", W_dstE, 4'd3);
      chk("norm_W_valE", W_valE, 64'h55);
      chk("norm_wb_dstE", wb_dstE, 4'd3);
      setM(3'd0, 4'h1, 4'hF, 4'hF, '0, '0);
      tick();
      chk("norm_retired", retired, 1);

      // Dual-write conflict
      setM(3'd1, 4'hB, 4'd4, 4'd4, 64'h8, 64'h100);
      tick();
      chk("conf_wb_dstE", wb_dstE, 4'hF);
      chk("conf_wb_dstM", wb_dstM, 4'd4);
      chk("conf_W_valM", W_valM, 64'h100);

      // Stall for three cycles, then release
      setM(3'd1, 4'h6, 4'd5, 4'hF, 64'h77, '0);
      tick();
      r = retired;
      W_stall = 1'b1;
      setM(3'd1, 4'h6, 4'd6, 4'hF, 64'h99, '0);
      repeat (3) tick();
      chk("stall_W_valE", W_valE, 64'h77);
      chk("stall_retired", retired, r);
      W_stall = 1'b0;
      tick();
      chk("rel_retired", retired, r + 1'b1);
      chk("rel_W_valE", W_valE, 64'h99);

      // Stall and bubble together hold; bubble alone flushes
      W_stall = 1'b1; W_bubble = 1'b1;
      tick();
      chk("sb_W_dstE", W_dstE, 4'd6);
      W_stall = 1'b0;
      tick();
      chk("bub_W_stat", W_stat, 3'd0);
      chk("bub_wb_dstE", wb_dstE, 4'hF);
      W_bubble = 1'b0;

      // Address fault
      setM(3'd3, 4'h5, 4'd2, 4'hF, 64'h1, '0);
      tick();
      chk("flt_wb_dstE", wb_dstE, 4'hF);
      setM(3'd1, 4'h6, 4'd7, 4'hF, 64'h2, '0);
      tick();
      chk("flt_halted", halted, 1'b1);
      chk("flt_stat", stat, 3'd3);
      r = retired;
      repeat (3) tick();
      chk("flt_stat_hold", stat, 3'd3);
      chk("flt_retired", retired, r);

      // Reset out of ERR, then halt, then reset out of HALT
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      setM(3'd2, 4'h0, 4'hF, 4'hF, '0, '0);
      tick();
      setM(3'd1, 4'h6, 4'd1, 4'hF, 64'h3, '0);
      tick();
      chk("hlt_halted", halted, 1'b1);
      chk("hlt_stat", stat, 3'd2);
      reset_n = 1'b0;
      tick();
      chk("hrst_W_stat", W_stat, 3'd0);
      chk("hrst_retired", retired, 0);
      chk("hrst_halted", halted, 1'b0);
      reset_n = 1'b1;

      // Counter wrap
      repeat (256) tick();
      chk("wrap_max", retired, 8'hFF);
      tick();
      chk("wrap_zero", retired, 0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [2:0] s;
         int sel;
         sel = int'($urandom_range(0, 99));
         s = (sel < 70) ? 3'd1 : (sel < 88) ? 3'd0 : (sel < 93) ? 3'd2 : (sel < 97) ? 3'd3 : 3'd4;
         setM(s, 4'($urandom_range(0, 11)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom});
         if ($urandom_range(0, 4) == 0) M_dstM = M_dstE;
         W_stall  = ($urandom_range(0, 4) == 0);
         W_bubble = ($urandom_range(0, 9) == 0);
         reset_n  = ($urandom_range(0, 24) != 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
